// File: rtl/rvfi_pkg.sv
// Shared types and constants for the RVFI commit tracker: the per-instruction
// shadow-ROB entry, the registered per-channel RVFI output record, and the
// conversion from one to the other applied at retirement.
package rvfi_pkg;

    localparam int XLEN    = 32;
    localparam int ORDER_W = 64;

    typedef struct packed {
        logic            valid;
        logic            done;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [XLEN-1:0] inst;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [XLEN-1:0] rd_wdata;
        logic [XLEN-1:0] mem_addr;
        logic [3:0]      mem_rmask;
        logic [3:0]      mem_wmask;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] mem_wdata;
    } rvfi_entry_t;

    typedef struct packed {
        logic               valid;
        logic [ORDER_W-1:0] order;
        logic [XLEN-1:0]    inst;
        logic [XLEN-1:0]    pc_rdata;
        logic [XLEN-1:0]    pc_wdata;
        logic [4:0]         rs1_addr;
        logic [4:0]         rs2_addr;
        logic [4:0]         rd_addr;
        logic [XLEN-1:0]    rs1_rdata;
        logic [XLEN-1:0]    rs2_rdata;
        logic [XLEN-1:0]    rd_wdata;
        logic [XLEN-1:0]    mem_addr;
        logic [3:0]         mem_rmask;
        logic [3:0]         mem_wmask;
        logic [XLEN-1:0]    mem_rdata;
        logic [XLEN-1:0]    mem_wdata;
    } rvfi_chan_t;

    // Build one RVFI channel record from a retiring entry. Register x0 reads
    // and writes are reported as zero and the memory address is word aligned.
    function automatic rvfi_chan_t make_chan(input rvfi_entry_t e,
                                             input logic [ORDER_W-1:0] order);
        rvfi_chan_t c;
        c           = '0;
        c.valid     = 1'b1;
        c.order     = order;
        c.inst      = e.inst;
        c.pc_rdata  = e.pc_rdata;
        c.pc_wdata  = e.pc_wdata;
        c.rs1_addr  = e.rs1_addr;
        c.rs2_addr  = e.rs2_addr;
        c.rd_addr   = e.rd_addr;
        c.rs1_rdata = (e.rs1_addr == 5'd0) ? '0 : e.rs1_rdata;
        c.rs2_rdata = (e.rs2_addr == 5'd0) ? '0 : e.rs2_rdata;
        c.rd_wdata  = (e.rd_addr  == 5'd0) ? '0 : e.rd_wdata;
        c.mem_addr  = {e.mem_addr[XLEN-1:2], 2'b00};
        c.mem_rmask = e.mem_rmask;
        c.mem_wmask = e.mem_wmask;
        c.mem_rdata = e.mem_rdata;
        c.mem_wdata = e.mem_wdata;
        return c;
    endfunction

endpackage

// File: rtl/rvfi_commit_tracker_if.sv
// Core-facing bundle of the commit tracker: dispatch, operand/writeback/LSU
// capture, commit control and the packed RVFI channel outputs.
interface rvfi_commit_tracker_if #(
    parameter int ROB_DEPTH    = 16,
    parameter int COMMIT_WIDTH = 2
);
    import rvfi_pkg::*;

    localparam int TAG_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

    logic                  alloc_valid;
    logic [XLEN-1:0]       alloc_pc;
    logic [XLEN-1:0]       alloc_inst;
    logic [4:0]            alloc_rs1;
    logic [4:0]            alloc_rs2;
    logic [4:0]            alloc_rd;
    logic [TAG_W-1:0]      alloc_tag;
    logic                  full;

    logic                  opnd_valid;
    logic [TAG_W-1:0]      opnd_tag;
    logic [XLEN-1:0]       opnd_rs1_rdata;
    logic [XLEN-1:0]       opnd_rs2_rdata;

    logic                  wb_valid;
    logic [TAG_W-1:0]      wb_tag;
    logic [XLEN-1:0]       wb_rd_wdata;
    logic [XLEN-1:0]       wb_pc_wdata;

    logic                  mem_valid;
    logic [TAG_W-1:0]      mem_tag;
    logic [XLEN-1:0]       mem_addr;
    logic [3:0]            mem_rmask;
    logic [3:0]            mem_wmask;
    logic [XLEN-1:0]       mem_rdata;
    logic [XLEN-1:0]       mem_wdata;

    logic [CNT_W-1:0]      commit_count;
    logic                  flush;

    logic [COMMIT_WIDTH-1:0]                 rvfi_valid;
    logic [COMMIT_WIDTH-1:0][ORDER_W-1:0]    rvfi_order;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]       rvfi_inst;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]       rvfi_pc_rdata;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]       rvfi_pc_wdata;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]       rvfi_rs1_rdata;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]       rvfi_rs2_rdata;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]       rvfi_rd_wdata;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]       rvfi_mem_addr;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]       rvfi_mem_rdata;
    logic [COMMIT_WIDTH-1:0][XLEN-1:0]       rvfi_mem_wdata;
    logic [COMMIT_WIDTH-1:0][4:0]            rvfi_rs1_addr;
    logic [COMMIT_WIDTH-1:0][4:0]            rvfi_rs2_addr;
    logic [COMMIT_WIDTH-1:0][4:0]            rvfi_rd_addr;
    logic [COMMIT_WIDTH-1:0][3:0]            rvfi_mem_rmask;
    logic [COMMIT_WIDTH-1:0][3:0]            rvfi_mem_wmask;
    logic                                    err;

    // Core side: drives dispatch/capture/commit, observes RVFI.
    modport master (
        output alloc_valid, alloc_pc, alloc_inst, alloc_rs1, alloc_rs2, alloc_rd,
        output opnd_valid, opnd_tag, opnd_rs1_rdata, opnd_rs2_rdata,
        output wb_valid, wb_tag, wb_rd_wdata, wb_pc_wdata,
        output mem_valid, mem_tag, mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata,
        output commit_count, flush,
        input  alloc_tag, full, err,
        input  rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
        input  rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
        input  rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
        input  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr, rvfi_mem_rmask, rvfi_mem_wmask
    );

    // Tracker side.
    modport slave (
        input  alloc_valid, alloc_pc, alloc_inst, alloc_rs1, alloc_rs2, alloc_rd,
        input  opnd_valid, opnd_tag, opnd_rs1_rdata, opnd_rs2_rdata,
        input  wb_valid, wb_tag, wb_rd_wdata, wb_pc_wdata,
        input  mem_valid, mem_tag, mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata,
        input  commit_count, flush,
        output alloc_tag, full, err,
        output rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
        output rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
        output rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
        output rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr, rvfi_mem_rmask, rvfi_mem_wmask
    );

endinterface

// File: rtl/rvfi_entry_ram.sv
// Shadow-ROB storage: ROB_DEPTH entries with one allocation write, three
// field-capture writes (operands, writeback, LSU) and COMMIT_WIDTH
// combinational read ports. Only the valid/done flags are reset.
module rvfi_entry_ram
    import rvfi_pkg::*;
#(
    parameter int ROB_DEPTH    = 16,
    parameter int COMMIT_WIDTH = 2,
    localparam int TAG_W       = $clog2(ROB_DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               alloc_we_i,
    input  logic [TAG_W-1:0]                   alloc_idx_i,
    input  rvfi_entry_t                        alloc_ent_i,
    input  logic                               opnd_we_i,
    input  logic [TAG_W-1:0]                   opnd_idx_i,
    input  logic [XLEN-1:0]                    rs1_rdata_i,
    input  logic [XLEN-1:0]                    rs2_rdata_i,
    input  logic                               wb_we_i,
    input  logic [TAG_W-1:0]                   wb_idx_i,
    input  logic [XLEN-1:0]                    rd_wdata_i,
    input  logic [XLEN-1:0]                    pc_wdata_i,
    input  logic                               mem_we_i,
    input  logic [TAG_W-1:0]                   mem_idx_i,
    input  logic [XLEN-1:0]                    mem_addr_i,
    input  logic [3:0]                         mem_rmask_i,
    input  logic [3:0]                         mem_wmask_i,
    input  logic [XLEN-1:0]                    mem_rdata_i,
    input  logic [XLEN-1:0]                    mem_wdata_i,
    input  logic [ROB_DEPTH-1:0]               retire_i,
    input  logic                               flush_i,
    input  logic [COMMIT_WIDTH-1:0][TAG_W-1:0] rd_idx_i,
    output rvfi_entry_t                        rd_ent_o [COMMIT_WIDTH],
    output logic [ROB_DEPTH-1:0]               valid_o
);

    rvfi_entry_t          mem_q [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] valid_q, valid_d;
    logic [ROB_DEPTH-1:0] done_q, done_d;

    // Next-state of the per-entry valid/done flags.
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (wb_we_i) begin
            done_d[wb_idx_i] = 1'b1;
        end
        if (alloc_we_i) begin
            valid_d[alloc_idx_i] = 1'b1;
            done_d[alloc_idx_i]  = 1'b0;
        end
        valid_d = valid_d & ~retire_i;
        done_d  = done_d  & ~retire_i;
        if (flush_i) begin
            valid_d = '0;
            done_d  = '0;
        end
    end

    // Flag registers.
    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Entry payload writes.
    // NOTE: the payload array is deliberately not reset; the valid/done flags gate every use of it.
    always_ff @(posedge clk) begin
        if (alloc_we_i) begin
            mem_q[alloc_idx_i] <= alloc_ent_i;
        end
        if (opnd_we_i) begin
            mem_q[opnd_idx_i].rs1_rdata <= rs1_rdata_i;
            mem_q[opnd_idx_i].rs2_rdata <= rs2_rdata_i;
        end
        if (wb_we_i) begin
            mem_q[wb_idx_i].rd_wdata <= rd_wdata_i;
            mem_q[wb_idx_i].pc_wdata <= pc_wdata_i;
        end
        if (mem_we_i) begin
            mem_q[mem_idx_i].mem_addr  <= mem_addr_i;
            mem_q[mem_idx_i].mem_rmask <= mem_rmask_i;
            mem_q[mem_idx_i].mem_wmask <= mem_wmask_i;
            mem_q[mem_idx_i].mem_rdata <= mem_rdata_i;
            mem_q[mem_idx_i].mem_wdata <= mem_wdata_i;
        end
    end

    // Commit read ports, with the live flags merged in.
    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            rd_ent_o[i]       = mem_q[rd_idx_i[i]];
            rd_ent_o[i].valid = valid_q[rd_idx_i[i]];
            rd_ent_o[i].done  = done_q[rd_idx_i[i]];
        end
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/rvfi_commit_tracker.sv
// RVFI commit tracker: a shadow ROB indexed by the core's ROB tags. Entries
// are filled as instructions move through the pipeline and emitted, packed
// and in program order, on the RVFI channels one cycle after commit.
module rvfi_commit_tracker
    import rvfi_pkg::*;
#(
    parameter int ROB_DEPTH    = 16,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    rvfi_commit_tracker_if.slave bus
);

    localparam int TAG_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);
    localparam int CTR_W = TAG_W + 1;

    logic [TAG_W-1:0]   head_q, head_d;
    logic [TAG_W-1:0]   tail_q, tail_d;
    logic [CTR_W-1:0]   count_q, count_d;
    logic [ORDER_W-1:0] order_q, order_d;
    logic               err_q, err_d;
    rvfi_chan_t         chan_q [COMMIT_WIDTH];
    rvfi_chan_t         chan_d [COMMIT_WIDTH];

    logic                               full;
    logic                               alloc_we, opnd_we, wb_we, mem_we;
    logic                               capture_bad;
    logic                               over_width, over_count, commit_bad;
    logic [CNT_W-1:0]                   k;
    rvfi_entry_t                        alloc_ent;
    logic [ROB_DEPTH-1:0]               ent_valid;
    logic [ROB_DEPTH-1:0]               retire_mask;
    logic [COMMIT_WIDTH-1:0][TAG_W-1:0] rd_idx;
    rvfi_entry_t                        rd_ent [COMMIT_WIDTH];

    // Full is judged on the pre-commit occupancy; flush drops a same-cycle allocation.
    assign full     = (count_q == CTR_W'(ROB_DEPTH));
    assign alloc_we = bus.alloc_valid && !full && !bus.flush;

    // Captures only land on live entries.
    assign opnd_we = bus.opnd_valid && ent_valid[bus.opnd_tag];
    assign wb_we   = bus.wb_valid   && ent_valid[bus.wb_tag];
    assign mem_we  = bus.mem_valid  && ent_valid[bus.mem_tag];
    assign capture_bad = (bus.opnd_valid && !ent_valid[bus.opnd_tag]) ||
                         (bus.wb_valid   && !ent_valid[bus.wb_tag])   ||
                         (bus.mem_valid  && !ent_valid[bus.mem_tag]);

    // Fresh entry image: dispatch fields set, every captured field cleared.
    always_comb begin
        alloc_ent          = '0;
        alloc_ent.valid    = 1'b1;
        alloc_ent.pc_rdata = bus.alloc_pc;
        alloc_ent.inst     = bus.alloc_inst;
        alloc_ent.rs1_addr = bus.alloc_rs1;
        alloc_ent.rs2_addr = bus.alloc_rs2;
        alloc_ent.rd_addr  = bus.alloc_rd;
    end

    // Clamp the requested retire count to the channel count and the occupancy.
    always_comb begin
        over_width = 32'(bus.commit_count) > 32'(COMMIT_WIDTH);
        over_count = 32'(bus.commit_count) > 32'(count_q);
        k          = bus.commit_count;
        if (over_width) begin
            k = CNT_W'(COMMIT_WIDTH);
        end
        if (32'(k) > 32'(count_q)) begin
            k = CNT_W'(count_q);
        end
    end

    // Read addresses for the head window.
    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            rd_idx[i] = head_q + TAG_W'(i);
        end
    end

    // Retire the first k head entries onto channels 0..k-1; the rest stay zero.
    always_comb begin
        retire_mask = '0;
        commit_bad  = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            chan_d[i] = '0;
            if (i < int'(k)) begin
                retire_mask[rd_idx[i]] = 1'b1;
                if (!(rd_ent[i].valid && rd_ent[i].done)) begin
                    commit_bad = 1'b1;
                end
                chan_d[i] = make_chan(rd_ent[i], order_q + ORDER_W'(i));
            end
        end
    end

    // Pointer, occupancy, order and error next-state.
    always_comb begin
        head_d  = head_q + TAG_W'(k);
        order_d = order_q + ORDER_W'(k);
        tail_d  = bus.flush ? head_d : tail_q + TAG_W'(alloc_we);
        count_d = bus.flush ? '0 : count_q + CTR_W'(alloc_we) - CTR_W'(k);
        err_d   = err_q || (bus.alloc_valid && full) || over_width || over_count ||
                  commit_bad || capture_bad;
    end

    // Control state and registered RVFI channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            order_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                chan_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            order_q <= order_d;
            err_q   <= err_d;
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                chan_q[i] <= chan_d[i];
            end
        end
    end

    rvfi_entry_ram #(
        .ROB_DEPTH    (ROB_DEPTH),
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_ram (
        .clk         (clk),
        .rst         (rst),
        .alloc_we_i  (alloc_we),
        .alloc_idx_i (tail_q),
        .alloc_ent_i (alloc_ent),
        .opnd_we_i   (opnd_we),
        .opnd_idx_i  (bus.opnd_tag),
        .rs1_rdata_i (bus.opnd_rs1_rdata),
        .rs2_rdata_i (bus.opnd_rs2_rdata),
        .wb_we_i     (wb_we),
        .wb_idx_i    (bus.wb_tag),
        .rd_wdata_i  (bus.wb_rd_wdata),
        .pc_wdata_i  (bus.wb_pc_wdata),
        .mem_we_i    (mem_we),
        .mem_idx_i   (bus.mem_tag),
        .mem_addr_i  (bus.mem_addr),
        .mem_rmask_i (bus.mem_rmask),
        .mem_wmask_i (bus.mem_wmask),
        .mem_rdata_i (bus.mem_rdata),
        .mem_wdata_i (bus.mem_wdata),
        .retire_i    (retire_mask),
        .flush_i     (bus.flush),
        .rd_idx_i    (rd_idx),
        .rd_ent_o    (rd_ent),
        .valid_o     (ent_valid)
    );

    assign bus.alloc_tag = tail_q;
    assign bus.full      = full;
    assign bus.err       = err_q;

    // Fan the registered channel records out to the flat RVFI buses.
    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            bus.rvfi_valid[i]     = chan_q[i].valid;
            bus.rvfi_order[i]     = chan_q[i].order;
            bus.rvfi_inst[i]      = chan_q[i].inst;
            bus.rvfi_pc_rdata[i]  = chan_q[i].pc_rdata;
            bus.rvfi_pc_wdata[i]  = chan_q[i].pc_wdata;
            bus.rvfi_rs1_addr[i]  = chan_q[i].rs1_addr;
            bus.rvfi_rs2_addr[i]  = chan_q[i].rs2_addr;
            bus.rvfi_rd_addr[i]   = chan_q[i].rd_addr;
            bus.rvfi_rs1_rdata[i] = chan_q[i].rs1_rdata;
            bus.rvfi_rs2_rdata[i] = chan_q[i].rs2_rdata;
            bus.rvfi_rd_wdata[i]  = chan_q[i].rd_wdata;
            bus.rvfi_mem_addr[i]  = chan_q[i].mem_addr;
            bus.rvfi_mem_rmask[i] = chan_q[i].mem_rmask;
            bus.rvfi_mem_wmask[i] = chan_q[i].mem_wmask;
            bus.rvfi_mem_rdata[i] = chan_q[i].mem_rdata;
            bus.rvfi_mem_wdata[i] = chan_q[i].mem_wdata;
        end
    end

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Self-checking bench for rvfi_commit_tracker: directed scenarios plus a
// randomized run, all compared against a queue-style ROB model.
module tb_rvfi_commit_tracker;
    import rvfi_pkg::*;

    localparam int D    = 16;
    localparam int CW   = 2;
    localparam int TW   = 4;
    localparam int CNTW = 2;
    localparam int PW   = 376;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rvfi_commit_tracker_if #(.ROB_DEPTH(D), .COMMIT_WIDTH(CW)) bus ();
    rvfi_commit_tracker #(.ROB_DEPTH(D), .COMMIT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          valid;
        bit          done;
        logic [31:0] pc_rdata, pc_wdata, inst, rs1_rdata, rs2_rdata, rd_wdata;
        logic [31:0] mem_addr, mem_rdata, mem_wdata;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  rmask, wmask;
    } m_ent_t;

    m_ent_t          m_rob [D];
    int              m_head, m_tail, m_count;
    longint unsigned m_order;
    bit              m_err;
    logic [PW-1:0]   exp_chan [CW];

    int n_checks = 0;
    int n_fail   = 0;

    // Expected channel image, applying the RVFI reporting rules.
    function automatic logic [PW-1:0] pack_ent(m_ent_t e, longint unsigned ord);
        logic [31:0] r1, r2, rdw, ma;
        r1  = (e.rs1 == 0) ? 32'h0 : e.rs1_rdata;
        r2  = (e.rs2 == 0) ? 32'h0 : e.rs2_rdata;
        rdw = (e.rd  == 0) ? 32'h0 : e.rd_wdata;
        ma  = e.mem_addr & 32'hFFFF_FFFC;
        return {1'b1, ord, e.inst, e.pc_rdata, e.pc_wdata, e.rs1, e.rs2, e.rd,
                r1, r2, rdw, ma, e.rmask, e.wmask, e.mem_rdata, e.mem_wdata};
    endfunction

    function automatic logic [PW-1:0] pack_dut(int i);
        return {bus.rvfi_valid[i], bus.rvfi_order[i], bus.rvfi_inst[i], bus.rvfi_pc_rdata[i],
                bus.rvfi_pc_wdata[i], bus.rvfi_rs1_addr[i], bus.rvfi_rs2_addr[i], bus.rvfi_rd_addr[i],
                bus.rvfi_rs1_rdata[i], bus.rvfi_rs2_rdata[i], bus.rvfi_rd_wdata[i], bus.rvfi_mem_addr[i],
                bus.rvfi_mem_rmask[i], bus.rvfi_mem_wmask[i], bus.rvfi_mem_rdata[i], bus.rvfi_mem_wdata[i]};
    endfunction

    // Advance the model by one cycle using the inputs currently driven.
    function automatic void model_update();
        int  k;
        bit  was_full;
        for (int i = 0; i < CW; i++) exp_chan[i] = '0;
        if (rst) begin
            for (int j = 0; j < D; j++) begin
                m_rob[j].valid = 0;
                m_rob[j].done  = 0;
            end
            m_head = 0; m_tail = 0; m_count = 0; m_order = 0; m_err = 0;
            return;
        end
        was_full = (m_count == D);
        k = int'(bus.commit_count);
        if (k > CW)      begin m_err = 1; k = CW;      end
        if (k > m_count) begin m_err = 1; k = m_count; end
        for (int i = 0; i < k; i++) begin
            int idx = (m_head + i) % D;
            if (!(m_rob[idx].valid && m_rob[idx].done)) m_err = 1;
            exp_chan[i] = pack_ent(m_rob[idx], m_order + longint'(i));
        end
        if (bus.opnd_valid) begin
            if (!m_rob[bus.opnd_tag].valid) m_err = 1;
            else begin
                m_rob[bus.opnd_tag].rs1_rdata = bus.opnd_rs1_rdata;
                m_rob[bus.opnd_tag].rs2_rdata = bus.opnd_rs2_rdata;
            end
        end
        if (bus.wb_valid) begin
            if (!m_rob[bus.wb_tag].valid) m_err = 1;
            else begin
                m_rob[bus.wb_tag].rd_wdata = bus.wb_rd_wdata;
                m_rob[bus.wb_tag].pc_wdata = bus.wb_pc_wdata;
                m_rob[bus.wb_tag].done     = 1;
            end
        end
        if (bus.mem_valid) begin
            if (!m_rob[bus.mem_tag].valid) m_err = 1;
            else begin
                m_rob[bus.mem_tag].mem_addr  = bus.mem_addr;
                m_rob[bus.mem_tag].rmask     = bus.mem_rmask;
                m_rob[bus.mem_tag].wmask     = bus.mem_wmask;
                m_rob[bus.mem_tag].mem_rdata = bus.mem_rdata;
                m_rob[bus.mem_tag].mem_wdata = bus.mem_wdata;
            end
        end
        for (int i = 0; i < k; i++) begin
            m_rob[(m_head + i) % D].valid = 0;
            m_rob[(m_head + i) % D].done  = 0;
        end
        m_head  = (m_head + k) % D;
        m_order = m_order + longint'(k);
        m_count = m_count - k;
        if (bus.alloc_valid) begin
            if (was_full) m_err = 1;
            else if (!bus.flush) begin
                m_ent_t e;
                e.valid = 1; e.done = 0;
                e.pc_rdata = bus.alloc_pc; e.inst = bus.alloc_inst;
                e.rs1 = bus.alloc_rs1; e.rs2 = bus.alloc_rs2; e.rd = bus.alloc_rd;
                e.pc_wdata = 0; e.rs1_rdata = 0; e.rs2_rdata = 0; e.rd_wdata = 0;
                e.mem_addr = 0; e.rmask = 0; e.wmask = 0; e.mem_rdata = 0; e.mem_wdata = 0;
                m_rob[m_tail] = e;
                m_tail  = (m_tail + 1) % D;
                m_count = m_count + 1;
            end
        end
        if (bus.flush) begin
            for (int j = 0; j < D; j++) begin
                m_rob[j].valid = 0;
                m_rob[j].done  = 0;
            end
            m_tail  = m_head;
            m_count = 0;
        end
    endfunction

    task automatic idle();
        bus.alloc_valid = 0; bus.alloc_pc = 0; bus.alloc_inst = 0;
        bus.alloc_rs1 = 0; bus.alloc_rs2 = 0; bus.alloc_rd = 0;
        bus.opnd_valid = 0; bus.opnd_tag = 0; bus.opnd_rs1_rdata = 0; bus.opnd_rs2_rdata = 0;
        bus.wb_valid = 0; bus.wb_tag = 0; bus.wb_rd_wdata = 0; bus.wb_pc_wdata = 0;
        bus.mem_valid = 0; bus.mem_tag = 0; bus.mem_addr = 0; bus.mem_rmask = 0;
        bus.mem_wmask = 0; bus.mem_rdata = 0; bus.mem_wdata = 0;
        bus.commit_count = 0; bus.flush = 0;
    endtask

    // One clock: update the model, take the edge, sample 1 time unit later.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    task automatic do_alloc(logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
        bus.alloc_valid = 1; bus.alloc_pc = pc; bus.alloc_inst = pc ^ 32'h0000_0013;
        bus.alloc_rs1 = rs1; bus.alloc_rs2 = rs2; bus.alloc_rd = rd;
        step();
    endtask

    task automatic do_wb(int tag, logic [31:0] data);
        bus.wb_valid = 1; bus.wb_tag = TW'(tag); bus.wb_rd_wdata = data; bus.wb_pc_wdata = 32'h100 + 32'(tag);
        step();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < CW; i++) begin
            n_checks++;
            if (pack_dut(i) !== '0) begin n_fail++; $display("FAIL reset_chan%0d: got %h want 0", i, pack_dut(i)); end
        end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_checks++; if (bus.alloc_tag !== 4'd0) begin n_fail++; $display("FAIL reset_tag: got %0d want 0", bus.alloc_tag); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    endtask

    task automatic test_single();
        do_reset();
        do_alloc(32'h6000_0000, 5'd1, 5'd2, 5'd5);
        n_checks++; if (bus.alloc_tag !== 4'd1) begin n_fail++; $display("FAIL single_tag: got %0d want 1", bus.alloc_tag); end
        do_wb(0, 32'hDEAD_BEEF);
        bus.commit_count = 1; step();
        n_checks++; if (bus.rvfi_valid !== 2'b01) begin n_fail++; $display("FAIL single_valid: got %b want 01", bus.rvfi_valid); end
        n_checks++; if (bus.rvfi_order[0] !== 64'd0) begin n_fail++; $display("FAIL single_order: got %0d want 0", bus.rvfi_order[0]); end
        n_checks++; if (bus.rvfi_rd_wdata[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rd_wdata: got %h want deadbeef", bus.rvfi_rd_wdata[0]); end
        n_checks++; if (bus.rvfi_pc_rdata[0] !== 32'h6000_0000) begin n_fail++; $display("FAIL single_pc: got %h want 60000000", bus.rvfi_pc_rdata[0]); end
        n_checks++; if (pack_dut(0) !== exp_chan[0]) begin n_fail++; $display("FAIL single_chan0: got %h want %h", pack_dut(0), exp_chan[0]); end
        step();
        n_checks++; if (pack_dut(0) !== '0) begin n_fail++; $display("FAIL single_idle: got %h want 0", pack_dut(0)); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < D; i++) do_alloc(32'h1000 + 32'(4 * i), 5'd3, 5'd4, 5'(i + 1));
        n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", bus.full); end
        do_alloc(32'hBAD0, 5'd1, 5'd1, 5'd1);
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL fill_overflow_err: got %b want 1", bus.err); end
        n_checks++; if (bus.alloc_tag !== 4'd0) begin n_fail++; $display("FAIL fill_overflow_tag: got %0d want 0", bus.alloc_tag); end
        for (int i = 0; i < D; i++) do_wb(i, 32'hA000 + 32'(i));
        for (int c = 0; c < D / 2; c++) begin
            bus.commit_count = 2; step();
            n_checks++;
            if (bus.rvfi_valid !== 2'b11 || bus.rvfi_order[0] !== 64'(2 * c) || bus.rvfi_order[1] !== 64'(2 * c + 1))
                begin n_fail++; $display("FAIL fill_pair%0d: got v=%b o=%0d,%0d want 11 %0d,%0d", c, bus.rvfi_valid, bus.rvfi_order[0], bus.rvfi_order[1], 2 * c, 2 * c + 1); end
            n_checks++;
            if (pack_dut(0) !== exp_chan[0] || pack_dut(1) !== exp_chan[1])
                begin n_fail++; $display("FAIL fill_data%0d: got %h want %h", c, pack_dut(1), exp_chan[1]); end
        end
        n_checks++; if (bus.full !== 1'b0 || bus.alloc_tag !== 4'd0) begin n_fail++; $display("FAIL fill_drained: got full=%b tag=%0d want 0 0", bus.full, bus.alloc_tag); end
        do_alloc(32'h2000, 5'd0, 5'd0, 5'd1);
        n_checks++; if (bus.alloc_tag !== 4'd1) begin n_fail++; $display("FAIL fill_wrap_tag: got %0d want 1", bus.alloc_tag); end
    endtask

    task automatic test_zero_fields();
        do_reset();
        do_alloc(32'h3000, 5'd0, 5'd7, 5'd0);
        do_alloc(32'h3004, 5'd8, 5'd9, 5'd10);
        bus.opnd_valid = 1; bus.opnd_tag = 0; bus.opnd_rs1_rdata = 32'h5555; bus.opnd_rs2_rdata = 32'h7777;
        bus.wb_valid = 1; bus.wb_tag = 0; bus.wb_rd_wdata = 32'h1234; bus.wb_pc_wdata = 32'h3004;
        bus.mem_valid = 1; bus.mem_tag = 1; bus.mem_addr = 32'h1003; bus.mem_wmask = 4'b1000;
        bus.mem_wdata = 32'hAABB_CCDD;
        step();
        do_wb(1, 32'h0);
        bus.commit_count = 2; step();
        n_checks++; if (bus.rvfi_rd_wdata[0] !== 32'h0) begin n_fail++; $display("FAIL x0_rd_wdata: got %h want 0", bus.rvfi_rd_wdata[0]); end
        n_checks++; if (bus.rvfi_rs1_rdata[0] !== 32'h0 || bus.rvfi_rs2_rdata[0] !== 32'h7777) begin n_fail++; $display("FAIL x0_rs_rdata: got %h %h want 0 7777", bus.rvfi_rs1_rdata[0], bus.rvfi_rs2_rdata[0]); end
        n_checks++; if (bus.rvfi_mem_addr[1] !== 32'h1000 || bus.rvfi_mem_wmask[1] !== 4'b1000) begin n_fail++; $display("FAIL store_addr: got %h/%b want 1000/1000", bus.rvfi_mem_addr[1], bus.rvfi_mem_wmask[1]); end
        n_checks++; if (pack_dut(1) !== exp_chan[1]) begin n_fail++; $display("FAIL store_chan1: got %h want %h", pack_dut(1), exp_chan[1]); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 6; i++) do_alloc(32'h4000 + 32'(4 * i), 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 6; i++) do_wb(i, 32'hF0 + 32'(i));
        bus.commit_count = 1; step();
        bus.commit_count = 1; bus.flush = 1;
        bus.alloc_valid = 1; bus.alloc_pc = 32'hDEAD; step();
        n_checks++; if (bus.rvfi_valid !== 2'b01 || bus.rvfi_order[0] !== 64'd1) begin n_fail++; $display("FAIL flush_commit: got v=%b o=%0d want 01 1", bus.rvfi_valid, bus.rvfi_order[0]); end
        n_checks++; if (bus.alloc_tag !== 4'd2) begin n_fail++; $display("FAIL flush_tail: got %0d want 2", bus.alloc_tag); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL flush_err: got %b want 0", bus.err); end
        step();
        n_checks++; if (bus.rvfi_valid !== 2'b00) begin n_fail++; $display("FAIL flush_quiet: got %b want 00", bus.rvfi_valid); end
        do_alloc(32'h5000, 5'd1, 5'd2, 5'd3);
        do_wb(2, 32'h77);
        bus.commit_count = 1; step();
        n_checks++; if (bus.rvfi_order[0] !== 64'd2 || pack_dut(0) !== exp_chan[0]) begin n_fail++; $display("FAIL flush_next_order: got %0d want 2", bus.rvfi_order[0]); end
    endtask

    task automatic test_not_done();
        do_reset();
        do_alloc(32'h7000, 5'd1, 5'd2, 5'd3);
        bus.commit_count = 1; step();
        n_checks++; if (bus.rvfi_valid[0] !== 1'b1 || bus.err !== 1'b1) begin n_fail++; $display("FAIL not_done: got v=%b err=%b want 1 1", bus.rvfi_valid[0], bus.err); end
        n_checks++; if (pack_dut(0) !== exp_chan[0]) begin n_fail++; $display("FAIL not_done_chan: got %h want %h", pack_dut(0), exp_chan[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) do_alloc(32'h8000 + 32'(4 * i), 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 5; i++) do_wb(i, 32'h9);
        bus.commit_count = 2;
        rst = 1; step(); rst = 0;
        n_checks++; if (bus.rvfi_valid !== 2'b00 || bus.alloc_tag !== 4'd0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got v=%b tag=%0d err=%b want 00 0 0", bus.rvfi_valid, bus.alloc_tag, bus.err); end
        do_alloc(32'h9000, 5'd1, 5'd2, 5'd3);
        do_wb(0, 32'h42);
        bus.commit_count = 2; step();
        n_checks++; if (bus.rvfi_valid !== 2'b01 || bus.rvfi_order[0] !== 64'd0) begin n_fail++; $display("FAIL midrst_restart: got v=%b o=%0d want 01 0", bus.rvfi_valid, bus.rvfi_order[0]); end
        n_checks++; if (bus.err !== m_err || pack_dut(0) !== exp_chan[0]) begin n_fail++; $display("FAIL midrst_chan: got err=%b want %b", bus.err, m_err); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int lim;
            bus.alloc_valid = ($urandom_range(0, 99) < 55);
            bus.alloc_pc = $urandom; bus.alloc_inst = $urandom;
            bus.alloc_rs1 = 5'($urandom); bus.alloc_rs2 = 5'($urandom);
            bus.alloc_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            if (m_count > 0) begin
                bus.opnd_valid = $urandom_range(0, 1);
                bus.opnd_tag = TW'((m_head + $urandom_range(0, m_count - 1)) % D);
                bus.opnd_rs1_rdata = $urandom; bus.opnd_rs2_rdata = $urandom;
                bus.wb_valid = ($urandom_range(0, 99) < 70);
                bus.wb_tag = TW'((m_head + $urandom_range(0, m_count - 1)) % D);
                bus.wb_rd_wdata = $urandom; bus.wb_pc_wdata = $urandom;
                bus.mem_valid = $urandom_range(0, 1);
                bus.mem_tag = TW'((m_head + $urandom_range(0, m_count - 1)) % D);
                bus.mem_addr = $urandom; bus.mem_rmask = 4'($urandom); bus.mem_wmask = 4'($urandom);
                bus.mem_rdata = $urandom; bus.mem_wdata = $urandom;
            end
            lim = (m_count < CW) ? m_count : CW;
            if ($urandom_range(0, 19) == 0) bus.commit_count = CNTW'($urandom_range(0, 3));
            else bus.commit_count = CNTW'($urandom_range(0, lim));
            bus.flush = ($urandom_range(0, 29) == 0);
            step();
            for (int i = 0; i < CW; i++) begin
                n_checks++;
                if (pack_dut(i) !== exp_chan[i]) begin n_fail++; $display("FAIL rand_chan%0d cyc%0d: got %h want %h", i, cyc, pack_dut(i), exp_chan[i]); end
            end
            n_checks++;
            if (bus.alloc_tag !== TW'(m_tail) || bus.full !== (m_count == D) || bus.err !== m_err)
                begin n_fail++; $display("FAIL rand_ctrl cyc%0d: got tag=%0d full=%b err=%b want %0d %b %b", cyc, bus.alloc_tag, bus.full, bus.err, m_tail, m_count == D, m_err); end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_fill();
        test_zero_fields();
        test_flush();
        test_not_done();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rvfi_commit_tracker.md
Name: rvfi_commit_tracker

Overview:
- Producer side of the RVFI commit interface. A shadow ROB that records per-instruction RVFI fields as the out-of-order core dispatches, issues, writes back and accesses memory.
- On commit it emits packed, program-ordered RVFI channel outputs with monotonically increasing order numbers. These outputs drive the verification monitor interface directly.
- Sits beside the core's ROB and is indexed by the same tags.

Parameters:
- ROB_DEPTH, 16, entries; power of two.
- COMMIT_WIDTH, 2, maximum retirements per cycle and number of RVFI channels driven (1..8).
- TAG_W, $clog2(ROB_DEPTH), derived tag width.
- CNT_W, $clog2(COMMIT_WIDTH+1), derived width of commit_count.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- alloc_valid  in  1  dispatch one instruction this cycle
- alloc_pc / alloc_inst  in  32 each  pc_rdata and instruction word
- alloc_rs1 / alloc_rs2 / alloc_rd  in  5 each  architectural register addresses
- alloc_tag  out  TAG_W  tail tag assigned to the current allocation
- full  out  1  no free entry
- opnd_valid, opnd_tag, opnd_rs1_rdata, opnd_rs2_rdata  in  1, TAG_W, 32, 32  operand capture at issue
- wb_valid, wb_tag, wb_rd_wdata, wb_pc_wdata  in  1, TAG_W, 32, 32  writeback; marks the entry done
- mem_valid, mem_tag, mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata  in  1, TAG_W, 32, 4, 4, 32, 32  LSU report
- commit_count  in  CNT_W  number of head entries retiring this cycle
- flush  in  1  discard all uncommitted entries
- rvfi_valid  out  [COMMIT_WIDTH]  per-channel commit strobe
- rvfi_order  out  [COMMIT_WIDTH][63:0]  retirement sequence number
- rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata  out  [COMMIT_WIDTH][31:0]
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  out  [COMMIT_WIDTH][4:0]
- rvfi_mem_rmask, rvfi_mem_wmask  out  [COMMIT_WIDTH][3:0]
- err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (synchronous, active-high):
  - head = tail = 0, count = 0, order counter = 0.
  - All entry valid and done bits cleared; err = 0; full = 0.
  - All rvfi_* outputs = 0.
- Allocation:
  - When alloc_valid && !full, write the entry at tail: pc, inst, rs1/rs2/rd addresses; clear the rdata, mem fields and masks; set valid = 1, done = 0; tail++ (wraps mod ROB_DEPTH).
  - alloc_tag always presents tail combinationally.
  - full = (count == ROB_DEPTH) and is evaluated before this cycle's commit. An allocation while full is ignored and sets err.
- Field capture (opnd / wb / mem):
  - Each port writes its fields into the entry addressed by its tag in the same cycle; the value is visible the next cycle.
  - A capture addressed to an entry with valid = 0 is ignored and sets err.
  - wb sets done = 1. Opnd, wb and mem may all target the same entry in one cycle.
- Commit:
  - commit_count = k retires entries head..head+k-1, with wrap-around. Each must be valid && done; otherwise err is set and the entry is still emitted.
  - k > count, or k > COMMIT_WIDTH, sets err and is clamped.
  - Outputs are registered, one-cycle latency: in cycle N+1, channel i (i < k) carries entry head+i with rvfi_order = order + i. Channels i >= k have rvfi_valid = 0 and all their fields 0.
  - order += k; head += k; count updates as count + alloc - k.
  - rvfi_rd_wdata is forced to 0 when rd = 0; rs1/rs2 rdata are forced to 0 when the address is 0.
  - rvfi_mem_addr = {addr[31:2], 2'b00}.
  - Packing is contiguous from channel 0 in program order.
- Capture to an entry committing in the same cycle: not forwarded; the entry must be done one cycle earlier, else err.
- Flush:
  - The same-cycle commit is processed first (those outputs are still emitted).
  - All remaining entries are invalidated; tail = head after commit; count = 0. A same-cycle allocation is dropped.
  - The order counter is unaffected.
- Order counter: 64-bit; wraps naturally.

Decomposition:
- Shared package rvfi_pkg holds:
  - the rvfi_entry_t struct (valid, done, pc_rdata, pc_wdata, inst, rs1/rs2/rd addr, rs1/rs2/rd data, mem addr/rmask/wmask/rdata/wdata);
  - the rvfi_chan_t output struct;
  - constants XLEN = 32 and ORDER_W = 64.
- One sub-module, rvfi_entry_ram: ROB_DEPTH x rvfi_entry_t register file with 1 alloc write, 3 field-capture writes and COMMIT_WIDTH read ports.

Test Plan:
- Reset → all outputs 0, full = 0, alloc_tag = 0. Allocate, wb and commit 1 instruction with alloc_pc = 0x60000000, rd = 5, wb_rd_wdata = 0xDEADBEEF → next cycle: rvfi_valid[0] = 1, order = 0, rd_wdata = 0xDEADBEEF, rvfi_valid[1] = 0.
- Fill 16 entries → full = 1; a 17th alloc → ignored and err = 1. wb all entries, commit 2/cycle → orders 0..15 in pairs; tags wrap to 0 on refill.
- Entry with rd = 0 and wb_rd_wdata = 0x1234 → rvfi_rd_wdata = 0. Store with mem_addr = 0x1003, wmask = 4'b1000 → rvfi_mem_addr = 0x1000.
- 6 entries allocated, flush in the same cycle as commit_count = 1 → exactly one output (order n); next alloc_tag = head; the next commit's order = n+1.
- commit_count = 1 on an entry without wb → err = 1, entry still emitted.
- Assert rst mid-stream with 5 entries live → next cycle all rvfi_valid = 0, count = 0, and the order restarts at 0.
